// File: rtl/mux_pkg.sv
// Shared types and helpers for the packet arbitration multiplexer.
package mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } mux_state_e;

  // Select-index width; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed lowest-index or round-robin search starting at a pointer.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter arb_mode_e   MODE  = ARB_RR,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] winner_o,
  output logic             any_o
);

  int unsigned      idx;
  logic [SEL_W-1:0] idx_sel;
  logic             found;

  // Scan the request vector from the start index, wrapping once; first hit wins.
  always_comb begin
    winner_o = '0;
    any_o    = |req_i;
    found    = 1'b0;
    idx      = 0;
    idx_sel  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (MODE == ARB_RR) begin
        idx = 32'(ptr_i) + i;
      end else begin
        idx = i;
      end
      if (idx >= N) begin
        idx = idx - N;
      end
      idx_sel = idx[SEL_W-1:0];
      if (!found && req_i[idx_sel]) begin
        found    = 1'b1;
        winner_o = idx_sel;
      end
    end
  end

endmodule

// File: rtl/packet_arb_mux.sv
// N-input packet-atomic stream mux. A grant is held from the first beat until the
// granted packet's last beat is accepted; input 0 may take a zero-latency path when idle.
module packet_arb_mux
  import mux_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_NUM_INPUTS = 4,
  parameter arb_mode_e   P_ARB_MODE   = ARB_RR,
  parameter int unsigned P_FAST0      = 1,
  localparam int unsigned SEL_W       = sel_width(P_NUM_INPUTS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [P_NUM_INPUTS-1:0]                valid_in,
  input  logic [P_NUM_INPUTS-1:0]                last_in,
  input  logic [P_NUM_INPUTS*P_DATA_WIDTH-1:0]   data_in,
  output logic [P_NUM_INPUTS-1:0]                ready_in,
  output logic                                   valid_out,
  output logic                                   last_out,
  output logic [P_DATA_WIDTH-1:0]                data_out,
  input  logic                                   ready_out,
  output logic [SEL_W-1:0]                       sel_out,
  output logic                                   active_out
);

  mux_state_e       state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0] arb_winner;
  logic             arb_any;
  logic             fast_win;

  logic [P_DATA_WIDTH-1:0] data_arr [P_NUM_INPUTS];

  for (genvar gi = 0; gi < P_NUM_INPUTS; gi++) begin : g_unpack
    assign data_arr[gi] = data_in[gi*P_DATA_WIDTH +: P_DATA_WIDTH];
  end

  rr_arbiter #(
    .N     (P_NUM_INPUTS),
    .MODE  (P_ARB_MODE),
    .SEL_W (SEL_W)
  ) u_arb (
    .req_i    (valid_in),
    .ptr_i    (rr_ptr_q),
    .winner_o (arb_winner),
    .any_o    (arb_any)
  );

  // Data follows the selected index; in IDLE that is input 0.
  assign data_out = data_arr[sel_out];

  // Next-state and output decode; ready never depends on any valid_in.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    sel_out    = '0;
    valid_out  = 1'b0;
    last_out   = 1'b0;
    ready_in   = '0;
    active_out = 1'b0;
    fast_win   = (P_FAST0 != 0) && valid_in[0];

    unique case (state_q)
      StIdle: begin
        if (P_FAST0 != 0) begin
          valid_out   = valid_in[0];
          last_out    = last_in[0];
          // Held low while in reset so no beat is accepted before release.
          ready_in[0] = ready_out & rst_n;
        end
        if (fast_win) begin
          // A single-beat packet accepted on the fast path leaves the state untouched.
          if (!(ready_out && last_in[0])) begin
            state_d = StLocked;
            grant_d = '0;
          end
        end else if (arb_any) begin
          state_d = StLocked;
          grant_d = arb_winner;
        end
      end
      StLocked: begin
        sel_out           = grant_q;
        active_out        = 1'b1;
        valid_out         = valid_in[grant_q];
        last_out          = last_in[grant_q];
        ready_in[grant_q] = ready_out;
        if (valid_out && ready_out && last_out) begin
          state_d = StIdle;
          if (P_ARB_MODE == ARB_RR) begin
            rr_ptr_d = (grant_q == SEL_W'(P_NUM_INPUTS - 1)) ? '0 : grant_q + SEL_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_packet_arb_mux.sv
// Directed bench for packet_arb_mux: three configurations share one stimulus bus.
//   u_a: RR, no fast path   u_b: FIXED, fast path   u_c: RR, fast path
module tb_packet_arb_mux;
  import mux_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   valid_in;
  logic [3:0]   last_in;
  logic [127:0] data_in;
  logic         ready_out;

  logic [3:0]  a_ready_in, b_ready_in, c_ready_in;
  logic        a_valid, b_valid, c_valid;
  logic        a_last, b_last, c_last;
  logic [31:0] a_data, b_data, c_data;
  logic [1:0]  a_sel, b_sel, c_sel;
  logic        a_active, b_active, c_active;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  packet_arb_mux #(.P_DATA_WIDTH(32), .P_NUM_INPUTS(4), .P_ARB_MODE(ARB_RR), .P_FAST0(0)) u_a (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .last_in(last_in), .data_in(data_in),
    .ready_in(a_ready_in), .valid_out(a_valid), .last_out(a_last), .data_out(a_data),
    .ready_out(ready_out), .sel_out(a_sel), .active_out(a_active)
  );

  packet_arb_mux #(.P_DATA_WIDTH(32), .P_NUM_INPUTS(4), .P_ARB_MODE(ARB_FIXED), .P_FAST0(1)) u_b (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .last_in(last_in), .data_in(data_in),
    .ready_in(b_ready_in), .valid_out(b_valid), .last_out(b_last), .data_out(b_data),
    .ready_out(ready_out), .sel_out(b_sel), .active_out(b_active)
  );

  packet_arb_mux #(.P_DATA_WIDTH(32), .P_NUM_INPUTS(4), .P_ARB_MODE(ARB_RR), .P_FAST0(1)) u_c (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .last_in(last_in), .data_in(data_in),
    .ready_in(c_ready_in), .valid_out(c_valid), .last_out(c_last), .data_out(c_data),
    .ready_out(ready_out), .sel_out(c_sel), .active_out(c_active)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid_in = '0; last_in = '0; data_in = '0; ready_out = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; valid_in = 4'b0001; last_in = 4'b0001; ready_out = 1'b1;
    data_in = '0; data_in[31:0] = 32'h0000_1234;
    #1;
    n_cmp++; if (a_active !== 1'b0) begin n_fail++; $display("FAIL reset_a_active got %b want 0", a_active); end
    n_cmp++; if (a_sel !== 2'd0) begin n_fail++; $display("FAIL reset_a_sel got %0d want 0", a_sel); end
    n_cmp++; if (a_ready_in !== 4'b0000) begin n_fail++; $display("FAIL reset_a_ready got %b want 0000", a_ready_in); end
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got %b want 0", a_valid); end
    n_cmp++; if (c_valid !== 1'b1) begin n_fail++; $display("FAIL reset_c_valid got %b want 1", c_valid); end
    n_cmp++; if (c_ready_in !== 4'b0000) begin n_fail++; $display("FAIL reset_c_ready got %b want 0000", c_ready_in); end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (c_active !== 1'b0) begin n_fail++; $display("FAIL reset_c_held got %b want 0", c_active); end
    n_cmp++; if (c_sel !== 2'd0) begin n_fail++; $display("FAIL reset_c_sel got %0d want 0", c_sel); end
  endtask

  // Four inputs always requesting 2-beat packets: grants 0,1,2,3,0 with an IDLE gap.
  task automatic test_rr_order();
    do_reset();
    valid_in = 4'hF; ready_out = 1'b1;
    for (int i = 0; i < 4; i++) data_in[i*32 +: 32] = 32'hA0 + i;
    for (int k = 0; k < 15; k++) begin
      int p;
      logic [1:0] es;
      p = k % 3;
      es = 2'((k / 3) % 4);
      last_in = (p == 2) ? 4'hF : 4'h0;
      #1;
      if (p == 0) begin
        n_cmp++; if (a_active !== 1'b0) begin n_fail++; $display("FAIL rr_gap_active k=%0d got %b want 0", k, a_active); end
        n_cmp++; if (a_ready_in !== 4'b0) begin n_fail++; $display("FAIL rr_gap_ready k=%0d got %b want 0000", k, a_ready_in); end
        n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap_valid k=%0d got %b want 0", k, a_valid); end
      end else begin
        n_cmp++; if (a_active !== 1'b1) begin n_fail++; $display("FAIL rr_active k=%0d got %b want 1", k, a_active); end
        n_cmp++; if (a_sel !== es) begin n_fail++; $display("FAIL rr_sel k=%0d got %0d want %0d", k, a_sel, es); end
        n_cmp++; if (a_last !== (p == 2)) begin n_fail++; $display("FAIL rr_last k=%0d got %b want %b", k, a_last, p == 2); end
        n_cmp++; if (a_data !== 32'hA0 + 32'(es)) begin n_fail++; $display("FAIL rr_data k=%0d got %h want %h", k, a_data, 32'hA0 + 32'(es)); end
        n_cmp++; if (a_ready_in !== (4'b0001 << es)) begin n_fail++; $display("FAIL rr_ready k=%0d got %b want %b", k, a_ready_in, 4'b0001 << es); end
      end
      @(negedge clk);
    end
  endtask

  // Fixed priority with inputs 1 and 3 requesting: input 1 wins every time.
  task automatic test_fixed();
    do_reset();
    valid_in = 4'b1010; last_in = 4'b1111; ready_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k % 2 == 0) begin
        n_cmp++; if (b_active !== 1'b0) begin n_fail++; $display("FAIL fix_idle_active k=%0d got %b want 0", k, b_active); end
        n_cmp++; if (b_ready_in !== 4'b0001) begin n_fail++; $display("FAIL fix_idle_ready k=%0d got %b want 0001", k, b_ready_in); end
        n_cmp++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL fix_idle_valid k=%0d got %b want 0", k, b_valid); end
      end else begin
        n_cmp++; if (b_sel !== 2'd1) begin n_fail++; $display("FAIL fix_sel k=%0d got %0d want 1", k, b_sel); end
        n_cmp++; if (b_ready_in !== 4'b0010) begin n_fail++; $display("FAIL fix_ready k=%0d got %b want 0010", k, b_ready_in); end
        n_cmp++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL fix_valid k=%0d got %b want 1", k, b_valid); end
      end
      @(negedge clk);
    end
  endtask

  // Single-beat packet on the fast path: same-cycle transfer, no lock, no echo.
  task automatic test_fast_single();
    do_reset();
    valid_in = 4'b0001; last_in = 4'b0001; ready_out = 1'b1; data_in[31:0] = 32'h0000_F00D;
    #1;
    n_cmp++; if (c_valid !== 1'b1) begin n_fail++; $display("FAIL fast_valid got %b want 1", c_valid); end
    n_cmp++; if (c_last !== 1'b1) begin n_fail++; $display("FAIL fast_last got %b want 1", c_last); end
    n_cmp++; if (c_data !== 32'h0000_F00D) begin n_fail++; $display("FAIL fast_data got %h want 0000f00d", c_data); end
    n_cmp++; if (c_ready_in !== 4'b0001) begin n_fail++; $display("FAIL fast_ready got %b want 0001", c_ready_in); end
    n_cmp++; if (c_active !== 1'b0) begin n_fail++; $display("FAIL fast_active got %b want 0", c_active); end
    @(negedge clk);
    valid_in = '0; last_in = '0;
    #1;
    n_cmp++; if (c_active !== 1'b0) begin n_fail++; $display("FAIL fast_after_active got %b want 0", c_active); end
    n_cmp++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL fast_after_valid got %b want 0", c_valid); end
    n_cmp++; if (b_active !== 1'b0) begin n_fail++; $display("FAIL fast_after_b_active got %b want 0", b_active); end
  endtask

  // Input 2, three beats with a two-cycle bubble and ready toggling.
  task automatic test_bubble();
    logic [3:0]  v_t   [9] = '{4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
    logic [3:0]  l_t   [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0};
    logic [31:0] d_t   [9] = '{32'hB0, 32'hB0, 32'hB0, 0, 0, 32'hB1, 32'hB2, 32'hB2, 0};
    logic        r_t   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        act_t [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        val_t [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_d [3] = '{32'hB0, 32'hB1, 32'hB2};
    int beats = 0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      valid_in = v_t[k]; last_in = l_t[k]; ready_out = r_t[k]; data_in[64 +: 32] = d_t[k];
      #1;
      n_cmp++; if (a_active !== act_t[k]) begin n_fail++; $display("FAIL bub_active k=%0d got %b want %b", k, a_active, act_t[k]); end
      n_cmp++; if (a_valid !== val_t[k]) begin n_fail++; $display("FAIL bub_valid k=%0d got %b want %b", k, a_valid, val_t[k]); end
      if (act_t[k]) begin
        n_cmp++; if (a_sel !== 2'd2) begin n_fail++; $display("FAIL bub_sel k=%0d got %0d want 2", k, a_sel); end
      end
      if (a_valid === 1'b1 && ready_out) begin
        if (beats < 3) begin
          n_cmp++; if (a_data !== exp_d[beats]) begin n_fail++; $display("FAIL bub_data beat=%0d got %h want %h", beats, a_data, exp_d[beats]); end
        end
        beats++;
      end
      @(negedge clk);
    end
    n_cmp++; if (beats !== 3) begin n_fail++; $display("FAIL bub_beats got %0d want 3", beats); end
  endtask

  // rr_ptr parked at 3; inputs 0 and 3 arrive together: 0 wins, then 3.
  task automatic test_fast_vs_rr();
    logic [3:0]  v_t   [7] = '{4'h4, 4'h4, 4'h9, 4'h9, 4'h8, 4'h8, 4'h0};
    logic [3:0]  l_t   [7] = '{4'h4, 4'h4, 4'h0, 4'h1, 4'h8, 4'h8, 4'h0};
    logic [31:0] d0_t  [7] = '{0, 0, 32'hC0, 32'hC1, 0, 0, 0};
    logic        act_t [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sel_t [7] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
    logic        val_t [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  rdy_t [7] = '{4'h1, 4'h4, 4'h1, 4'h1, 4'h1, 4'h8, 4'h1};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      valid_in = v_t[k]; last_in = l_t[k]; ready_out = 1'b1; data_in[31:0] = d0_t[k];
      #1;
      n_cmp++; if (c_active !== act_t[k]) begin n_fail++; $display("FAIL fvr_active k=%0d got %b want %b", k, c_active, act_t[k]); end
      n_cmp++; if (c_sel !== sel_t[k]) begin n_fail++; $display("FAIL fvr_sel k=%0d got %0d want %0d", k, c_sel, sel_t[k]); end
      n_cmp++; if (c_valid !== val_t[k]) begin n_fail++; $display("FAIL fvr_valid k=%0d got %b want %b", k, c_valid, val_t[k]); end
      n_cmp++; if (c_ready_in !== rdy_t[k]) begin n_fail++; $display("FAIL fvr_ready k=%0d got %b want %b", k, c_ready_in, rdy_t[k]); end
      if (d0_t[k] != 0) begin
        n_cmp++; if (c_data !== d0_t[k]) begin n_fail++; $display("FAIL fvr_data k=%0d got %h want %h", k, c_data, d0_t[k]); end
      end
      @(negedge clk);
    end
  endtask

  // Reset mid-packet on input 1 after rr_ptr was moved to 3.
  task automatic test_reset_mid();
    do_reset();
    valid_in = 4'b0100; last_in = 4'b0100;
    @(negedge clk);
    #1;
    n_cmp++; if (a_sel !== 2'd2) begin n_fail++; $display("FAIL rmid_pre_sel got %0d want 2", a_sel); end
    @(negedge clk);
    valid_in = 4'b0010; last_in = 4'b0000;
    @(negedge clk);
    #1;
    n_cmp++; if (a_sel !== 2'd1) begin n_fail++; $display("FAIL rmid_lock_sel got %0d want 1", a_sel); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_active !== 1'b0) begin n_fail++; $display("FAIL rmid_active got %b want 0", a_active); end
    n_cmp++; if (a_sel !== 2'd0) begin n_fail++; $display("FAIL rmid_sel got %0d want 0", a_sel); end
    n_cmp++; if (a_ready_in !== 4'b0000) begin n_fail++; $display("FAIL rmid_ready got %b want 0000", a_ready_in); end
    @(negedge clk);
    rst_n = 1'b1; valid_in = 4'hF;
    #1;
    n_cmp++; if (a_active !== 1'b0) begin n_fail++; $display("FAIL rmid_rel_active got %b want 0", a_active); end
    @(negedge clk);
    #1;
    n_cmp++; if (a_active !== 1'b1) begin n_fail++; $display("FAIL rmid_regrant_active got %b want 1", a_active); end
    n_cmp++; if (a_sel !== 2'd0) begin n_fail++; $display("FAIL rmid_regrant_sel got %0d want 0", a_sel); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid_in = '0; last_in = '0; data_in = '0; ready_out = 1'b0;
    test_reset();
    test_rr_order();
    test_fixed();
    test_fast_single();
    test_bubble();
    test_fast_vs_rr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
